// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// async_fifo_pkg : shared types for the async FIFO write-side logic
// Rev 1.0
// ============================================================================
package async_fifo_pkg;

    typedef enum logic [1:0] {
        WQ_EMPTY = 2'd0,
        WQ_ONE   = 2'd1,
        WQ_TWO   = 2'd2
    } wq_state_e;

endpackage
`default_nettype wire

// File: rtl/wfifo_push_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit event counter, wrapping or saturating at all-ones
// Rev 1.0
// ============================================================================
module sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic         wclk_i,
    input  logic         wrst_n_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_max = {W{1'b1}};

    logic [W-1:0] r_cnt;
    logic         w_hold;

    generate
        if (SATURATE) begin : g_sat
            assign w_hold = (r_cnt == c_max);
        end else begin : g_wrap
            assign w_hold = 1'b0;
        end
    endgenerate

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            r_cnt <= '0;
        end else if (inc && !w_hold) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/wfifo_push_ctrl.sv
`default_nettype none
// ============================================================================
// wfifo_push_ctrl : valid/ready front-end with 2-entry skid buffer driving the
//                   async FIFO write port, plus write/stall debug counters
// Rev 1.0
// ============================================================================
module wfifo_push_ctrl
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE    = 8,
    parameter int CNTW        = 16,
    parameter int AF_THROTTLE = 1
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                s_valid,
    input  logic [DATASIZE-1:0] s_data,
    output logic                s_ready,
    input  logic                fifo_full,
    input  logic                fifo_almost_full,
    output logic                wen,
    output logic [DATASIZE-1:0] wdata,
    output logic [CNTW-1:0]     wr_cnt,
    output logic [CNTW-1:0]     stall_cnt
);

    localparam bit c_af_throttle = (AF_THROTTLE != 0);

    wq_state_e           r_state;
    wq_state_e           w_state_next;
    logic [DATASIZE-1:0] r_main_data;
    logic [DATASIZE-1:0] w_main_next;
    logic [DATASIZE-1:0] r_skid_data;
    logic [DATASIZE-1:0] w_skid_next;
    logic                r_s_ready;
    logic                w_s_ready_next;
    logic                w_push;
    logic                w_pop;
    logic                w_main_valid;

    assign w_main_valid = (r_state != WQ_EMPTY);
    assign w_push       = s_valid & r_s_ready;
    assign w_pop        = w_main_valid & ~fifo_full;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main_data;
        w_skid_next  = r_skid_data;
        case (r_state)
            WQ_EMPTY: begin
                if (w_push) begin
                    w_state_next = WQ_ONE;
                    w_main_next  = s_data;
                end
            end
            WQ_ONE: begin
                if (w_push && w_pop) begin
                    w_main_next = s_data;
                end else if (w_push) begin
                    w_state_next = WQ_TWO;
                    w_skid_next  = s_data;
                end else if (w_pop) begin
                    w_state_next = WQ_EMPTY;
                end
            end
            WQ_TWO: begin
                if (w_pop) begin
                    w_state_next = WQ_ONE;
                    w_main_next  = r_skid_data;
                end
            end
            default: begin
                w_state_next = WQ_EMPTY;
            end
        endcase
        // Ready looks at the next state, so the skid slot absorbs the one push
        // that can land while s_ready is still registered high.
        w_s_ready_next = (w_state_next != WQ_TWO) && !(c_af_throttle && fifo_almost_full);
    end

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            r_state     <= WQ_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_s_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_main_data <= w_main_next;
            r_skid_data <= w_skid_next;
            r_s_ready   <= w_s_ready_next;
        end
    end

    assign s_ready = r_s_ready;
    assign wen     = w_pop;
    assign wdata   = r_main_data;

    sat_counter #(
        .W        (CNTW),
        .SATURATE (1'b0)
    ) u_wr_cnt (
        .wclk_i   (wclk_i),
        .wrst_n_i (wrst_n_i),
        .inc      (w_pop),
        .cnt      (wr_cnt)
    );

    sat_counter #(
        .W        (CNTW),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .wclk_i   (wclk_i),
        .wrst_n_i (wrst_n_i),
        .inc      (w_main_valid & fifo_full),
        .cnt      (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_wfifo_push_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wfifo_push_ctrl : directed bench; main instance CNTW=8/AF_THROTTLE=1,
//                      second instance CNTW=16/AF_THROTTLE=0 on the same inputs
// Rev 1.0
// ============================================================================
module tb_wfifo_push_ctrl;

    logic        clk;
    logic        wrst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        fifo_full;
    logic        fifo_af;

    logic        s_ready;
    logic        wen;
    logic [7:0]  wdata;
    logic [7:0]  wr_cnt;
    logic [7:0]  stall_cnt;

    logic        s_ready2;
    logic        wen2;
    logic [7:0]  wdata2;
    logic [15:0] wr_cnt2;
    logic [15:0] stall_cnt2;

    int total = 0;
    int bad   = 0;

    wfifo_push_ctrl #(.DATASIZE(8), .CNTW(8), .AF_THROTTLE(1)) dut (
        .wclk_i           (clk),
        .wrst_n_i         (wrst_n),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_af),
        .wen              (wen),
        .wdata            (wdata),
        .wr_cnt           (wr_cnt),
        .stall_cnt        (stall_cnt)
    );

    wfifo_push_ctrl #(.DATASIZE(8), .CNTW(16), .AF_THROTTLE(0)) dut2 (
        .wclk_i           (clk),
        .wrst_n_i         (wrst_n),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready2),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_af),
        .wen              (wen2),
        .wdata            (wdata2),
        .wr_cnt           (wr_cnt2),
        .stall_cnt        (stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n    = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        fifo_full = 1'b1;
        fifo_af   = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'h00);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Release with full held for three cycles
        wrst_n  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h11;
        #1;
        chk("rel_s_ready_pre", 32'(s_ready), 32'd0);
        tick();
        chk("rel_s_ready_up", 32'(s_ready), 32'd1);
        chk("rel_wen_full", 32'(wen), 32'd0);
        tick();
        s_data = 8'h22;
        #1;
        chk("full_wen_hold", 32'(wen), 32'd0);
        tick();
        s_valid   = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("two_s_ready", 32'(s_ready), 32'd0);
        chk("drain_wen0", 32'(wen), 32'd1);
        chk("drain_wdata0", 32'(wdata), 32'h11);
        tick();
        chk("drain_wen1", 32'(wen), 32'd1);
        chk("drain_wdata1", 32'(wdata), 32'h22);
        chk("drain_s_ready", 32'(s_ready), 32'd1);
        tick();
        chk("drain_idle", 32'(wen), 32'd0);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);

        // Streaming 0x00..0x0F at one per cycle
        s_valid = 1'b1;
        s_data  = 8'h00;
        for (int k = 0; k < 16; k++) begin
            tick();
            s_data = 8'(k + 1);
            if (k == 15) s_valid = 1'b0;
            #1;
            chk("stream_wen", 32'(wen), 32'd1);
            chk("stream_wdata", 32'(wdata), 32'(k));
        end
        tick();
        chk("stream_idle", 32'(wen), 32'd0);
        chk("stream_wr_cnt", 32'(wr_cnt), 32'd18);

        // Full asserted right after 0x05 is written
        s_valid = 1'b1;
        s_data  = 8'h00;
        for (int k = 0; k < 6; k++) begin
            tick();
            s_data = 8'(k + 1);
            #1;
            chk("mid_wdata", 32'(wdata), 32'(k));
        end
        tick();
        fifo_full = 1'b1;
        s_data    = 8'h07;
        #1;
        chk("mid_full_wen", 32'(wen), 32'd0);
        chk("mid_full_wdata", 32'(wdata), 32'h06);
        chk("mid_full_ready", 32'(s_ready), 32'd1);
        tick();
        s_data = 8'h08;
        #1;
        chk("mid_ready_drop", 32'(s_ready), 32'd0);
        chk("mid_two_wen", 32'(wen), 32'd0);
        tick();
        fifo_full = 1'b0;
        #1;
        chk("resume_wen6", 32'(wen), 32'd1);
        chk("resume_wdata6", 32'(wdata), 32'h06);
        chk("resume_ready_lo", 32'(s_ready), 32'd0);
        tick();
        chk("resume_wdata7", 32'(wdata), 32'h07);
        chk("resume_ready_hi", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        #1;
        chk("resume_wen8", 32'(wen), 32'd1);
        chk("resume_wdata8", 32'(wdata), 32'h08);
        tick();
        chk("resume_idle", 32'(wen), 32'd0);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd27);
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd3);

        // Almost-full throttle
        tick();
        s_valid = 1'b1;
        s_data  = 8'hA0;
        fifo_af = 1'b1;
        tick();
        s_valid = 1'b0;
        #1;
        chk("af_ready", 32'(s_ready), 32'd0);
        chk("af_ready_nothrottle", 32'(s_ready2), 32'd1);
        chk("af_drain_wen", 32'(wen), 32'd1);
        chk("af_drain_wdata", 32'(wdata), 32'hA0);
        chk("af_drain_wen2", 32'(wen2), 32'd1);
        tick();
        chk("af_idle_wen", 32'(wen), 32'd0);
        chk("af_ready_hold", 32'(s_ready), 32'd0);
        chk("af_ready2_hold", 32'(s_ready2), 32'd1);
        fifo_af = 1'b0;
        tick();
        chk("af_ready_back", 32'(s_ready), 32'd1);

        // Stall counter saturation (CNTW=8) with main held valid
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'hC0;
        tick();
        s_valid = 1'b0;
        repeat (250) tick();
        chk("stall_253", 32'(stall_cnt), 32'd253);
        chk("stall_wen", 32'(wen), 32'd0);
        repeat (10) tick();
        chk("stall_sat", 32'(stall_cnt), 32'd255);
        repeat (50) tick();
        chk("stall_sat_hold", 32'(stall_cnt), 32'd255);
        chk("stall2_nosat", 32'(stall_cnt2), 32'd313);
        fifo_full = 1'b0;
        #1;
        chk("stall_release_wen", 32'(wen), 32'd1);
        chk("stall_release_wdata", 32'(wdata), 32'hC0);
        tick();
        chk("t5_wr_cnt", 32'(wr_cnt), 32'd29);

        // wr_cnt wrap: 227 more writes reach 256
        s_valid = 1'b1;
        s_data  = 8'h00;
        for (int k = 0; k < 226; k++) begin
            tick();
            s_data = 8'(k + 1);
        end
        tick();
        s_valid = 1'b0;
        #1;
        chk("wrap_255", 32'(wr_cnt), 32'd255);
        chk("wrap_last_wen", 32'(wen), 32'd1);
        tick();
        chk("wrap_0", 32'(wr_cnt), 32'd0);
        chk("wrap2_256", 32'(wr_cnt2), 32'd256);

        // Reset while in WQ_TWO
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'hE1;
        tick();
        s_data = 8'hE2;
        tick();
        s_valid = 1'b0;
        #1;
        chk("pre_rst_ready", 32'(s_ready), 32'd0);
        fifo_full = 1'b0;
        #1;
        chk("pre_rst_wdata", 32'(wdata), 32'hE1);
        wrst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(s_ready), 32'd0);
        chk("arst_wen", 32'(wen), 32'd0);
        chk("arst_wdata", 32'(wdata), 32'h00);
        chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_wr_cnt2", 32'(wr_cnt2), 32'd0);
        tick();
        tick();
        wrst_n = 1'b1;
        #1;
        chk("rel2_ready_pre", 32'(s_ready), 32'd0);
        tick();
        chk("rel2_ready", 32'(s_ready), 32'd1);
        chk("rel2_wen", 32'(wen), 32'd0);
        tick();
        tick();
        chk("no_stale_wen", 32'(wen), 32'd0);
        chk("no_stale_cnt", 32'(wr_cnt), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'hF0;
        tick();
        s_valid = 1'b0;
        #1;
        chk("post_rst_wen", 32'(wen), 32'd1);
        chk("post_rst_wdata", 32'(wdata), 32'hF0);
        tick();
        chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wfifo_push_ctrl.md
# wfifo_push_ctrl

Write-domain producer front-end for the async FIFO: accepts a valid/ready stream from upstream logic and drives the FIFO's write-enable/data port, never issuing a write while the FIFO reports full. A 2-entry skid buffer decouples the registered upstream `s_ready` from the FIFO's registered `fifo_full`/`fifo_almost_full` flags. Write and stall statistics counters are included for debug. The block sits entirely in the `wclk_i` domain, in front of the FIFO write-pointer/full logic.

## Interface
Parameters:
- DATASIZE, 8, payload width.
- CNTW, 16, width of statistics counters.
- AF_THROTTLE, 1, when 1, `fifo_almost_full` also deasserts `s_ready`.

Ports:
- wclk_i  in  1  write-domain clock.
- wrst_n_i  in  1  reset, asynchronous, active-low.
- s_valid  in  1  upstream data valid.
- s_data  in  DATASIZE  upstream payload.
- s_ready  out  1  upstream may transfer; registered.
- fifo_full  in  1  registered FIFO full flag; reads 1 during and just after reset.
- fifo_almost_full  in  1  registered FIFO almost-full flag.
- wen  out  1  FIFO write enable.
- wdata  out  DATASIZE  FIFO write data.
- wr_cnt  out  CNTW  count of FIFO writes issued; wraps.
- stall_cnt  out  CNTW  count of cycles with data held off by full; saturates.

## Operation
- push = s_valid & s_ready; pop = wen = main_valid & ~fifo_full; wdata = main_data (combinational from register).
- State machine (enum wq_state_e):
  - WQ_EMPTY: push -> WQ_ONE, main <= s_data.
  - WQ_ONE: push & pop -> WQ_ONE, main <= s_data; push & ~pop -> WQ_TWO, skid <= s_data; ~push & pop -> WQ_EMPTY; neither -> stay.
  - WQ_TWO: pop -> WQ_ONE, main <= skid; otherwise stay. No push is possible in WQ_TWO (s_ready is 0).
- main_valid = (state != WQ_EMPTY).
- s_ready next = (state_next != WQ_TWO) & ~(AF_THROTTLE & fifo_almost_full).
- Ordering: strict FIFO order; no data is dropped or duplicated under any sequence of full/valid.
- wr_cnt increments on every wen cycle and wraps from 2^CNTW-1 to 0.
- stall_cnt increments when main_valid & fifo_full, and holds at 2^CNTW-1.
- The FIFO's fifo_full reflects the pointer after the current cycle's write, so wen & ~fifo_full is exact. No extra guard cycle is required.

## Timing
- Reset values: state WQ_EMPTY, s_ready 0, wen 0, wdata 0, main/skid data 0, wr_cnt 0, stall_cnt 0.
- s_ready rises on the first wclk_i edge after reset release, provided throttle does not apply.
- Latency: push at edge N makes wen eligible in the cycle following edge N. wen is asserted there if fifo_full = 0.
- Full asserted: wen drops in the same cycle combinationally. Main holds its data, a push in WQ_ONE fills skid, and s_ready falls one edge later. The one-cycle s_ready lag is absorbed by skid.
- Full deasserts: wen in the same cycle. WQ_TWO drains to WQ_ONE, and s_ready returns on the following edge.
- Sustained throughput: 1 transfer/cycle with s_valid held and full low.
- Reset mid-operation: buffered entries are discarded, all outputs return to reset values asynchronously, and s_ready stays 0 until the first edge after release.

## Structure
- Shared package async_fifo_pkg holds typedef enum logic [1:0] wq_state_e {WQ_EMPTY, WQ_ONE, WQ_TWO}.
- Sub-module sat_counter (parameter W, SATURATE) is instanced for wr_cnt (SATURATE=0) and stall_cnt (SATURATE=1).
- All logic runs on wclk_i. No synchronizers live in this block.

## Test plan
- Reset release with fifo_full=1 for 3 cycles and s_valid=1, data 0x11, 0x22: wen stays 0 while full. After full drops, wen writes 0x11 then 0x22 in order. wr_cnt=2, stall_cnt≥1.
- Streaming 0x00..0x0F with full=0: 16 consecutive wen cycles, 1/cycle. wdata matches in order, wr_cnt=16.
- Full asserted mid-stream after 0x05 written: wen=0 next cycle, skid holds 0x07, s_ready drops one edge later. No loss; resume writes 0x06, 0x07, 0x08.
- AF_THROTTLE=1 with fifo_almost_full=1, full=0: s_ready=0 on the next edge while buffered entries still drain via wen. With AF_THROTTLE=0, s_ready stays 1.
- fifo_full held 1 for 2^CNTW+5 cycles with main valid: stall_cnt saturates at all-ones. Separately, wr_cnt wraps to 0 after 2^CNTW writes.
- wrst_n_i asserted while in WQ_TWO: immediately s_ready=0, wen=0, counters 0. After release, no stale data is written.
